glove_tracker: RTL and testbench
================================

Name: glove_tracker

Overview:
- Turns the camera pixel-classification stream into the glove inputs consumed by the ball state machine: glove position in mm (x, y) and a debounced closed flag.
- Instantiate once per glove (glove1, glove2). Each instance is fed by its own colour-match signal from the video front end.
- Per frame it accumulates the matching pixel coordinates and computes the centroid with a sequential divider. It then scales the centroid to mm and classifies open/closed from blob area.

Parameters:
- FRAME_W, 640, active pixels per line
- FRAME_H, 480, active lines per frame
- MM_PER_PX_X, 4, mm per pixel horizontally (integer)
- MM_PER_PX_Y, 4, mm per pixel vertically (integer)
- MIN_PIXELS, 64, blob area below which the glove is considered lost
- CLOSED_AREA, 900, blob area below which the glove is classified closed
- DEBOUNCE_FRAMES, 3, consecutive agreeing frames required to change glove_closed

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_valid  in  1  active-region pixel strobe
- pix_hit  in  1  pixel matches glove colour (qualified by pix_valid)
- hcount  in  11  pixel column, 0..FRAME_W-1
- vcount  in  10  pixel row, 0..FRAME_H-1
- frame_end  in  1  one-cycle pulse after the last active pixel of a frame
- glovex  out  16  glove x in mm
- glovey  out  16  glove y in mm, measured upward from the floor
- glove_closed  out  1  debounced closed flag
- glove_found  out  1  the last frame had at least MIN_PIXELS hits
- pos_valid  out  1  one-cycle pulse when the outputs have been updated

Behaviour:
- Reset: glovex=0, glovey=0, glove_closed=0, glove_found=0, pos_valid=0. Accumulators, debounce counter and divider are cleared; the FSM enters ACCUM.
- Reset mid-frame or mid-divide: that frame is discarded. Accumulation restarts on the next cycle.
- FSM states:
  - ACCUM
    - Each cycle with pix_valid&&pix_hit: sumx += hcount, sumy += vcount, count += 1.
    - Widths: sumx/sumy 28 bits, count 19 bits, so no overflow at 640x480.
    - frame_end → LATCH.
  - LATCH
    - count < MIN_PIXELS: glove_found<=0, glovex/glovey/glove_closed held, debounce counter unchanged, pos_valid pulsed, go to ACCUM.
    - Otherwise: latch the operands, clear the accumulators, go to DIVIDE.
  - DIVIDE
    - Two parallel restoring dividers, sumx/count and sumy/count, one quotient bit per cycle for 28 cycles.
    - Quotients are truncated (floor).
  - SCALE
    - glovex <= cx*MM_PER_PX_X.
    - glovey <= (FRAME_H-1-cy)*MM_PER_PX_Y.
    - Both truncated to 16 bits.
    - Update the closed classifier (below). glove_found<=1. Go to OUTPUT.
  - OUTPUT
    - pos_valid=1 for exactly this cycle. Go to ACCUM.
- Latency: frame_end to pos_valid is 31 cycles when the glove is found, 2 cycles when lost. This fits inside vertical blanking.
- Pixels and frame_end arriving while not in ACCUM are ignored. Accumulators are already cleared for the next frame.
- Closed classifier:
  - candidate = (count < CLOSED_AREA).
  - If candidate == glove_closed: debounce counter <= 0.
  - Else: counter increments. When it reaches DEBOUNCE_FRAMES-1 on a disagreeing frame, glove_closed toggles and the counter clears.
  - Lost frames do not touch the counter.
- Outputs are registered and hold their values between pos_valid pulses.

Optional Feature:
- Macro: GLOVE_TRACKER_SMOOTH_EN.
- Defined:
  - In SCALE, glovex <= (glovex_prev + new_x) >> 1, computed at 17 bits and truncated; glovey is treated the same way.
  - The first found frame after reset or after a lost frame loads the new value directly.
  - Latency is unchanged.
- Undefined: glovex/glovey are loaded directly from the new values.

Test Plan:
- Single 10x10 hit square at columns 100..109, rows 200..209, then frame_end → pos_valid 31 cycles later; glovex=416 (104*4), glovey=1100 ((479-204)*4), glove_found=1, glove_closed=0.
- 40 hits (< MIN_PIXELS) after a valid frame → pos_valid 2 cycles after frame_end; glove_found=0; glovex/glovey/glove_closed unchanged.
- Area 400 for 2 frames, then 1600, then 400 for 3 frames (DEBOUNCE_FRAMES=3) → glove_closed stays 0 until the pos_valid of the 3rd consecutive small frame, then becomes 1.
- reset asserted during DIVIDE → no pos_valid; outputs return to 0. The next full frame with a 10x10 square at (0,0) gives glovex=16, glovey=1900.
- Hits at (639,479) and (0,0) only, MIN_PIXELS=2 → centroid (319,239); glovex=1276, glovey=960.
- With GLOVE_TRACKER_SMOOTH_EN: frame at glovex 416, then a frame with centroid x=200 (800 mm) → glovex=416, then 608.

Source files
------------

// File: rtl/glove_tracker.sv
// Per-glove blob tracker: accumulates hit pixels per frame, divides for the centroid,
// scales to mm, debounces open/closed. Optional smoothing via GLOVE_TRACKER_SMOOTH_EN.
module glove_tracker #(
  parameter int unsigned FRAME_W         = 640,
  parameter int unsigned FRAME_H         = 480,
  parameter int unsigned MM_PER_PX_X     = 4,
  parameter int unsigned MM_PER_PX_Y     = 4,
  parameter int unsigned MIN_PIXELS      = 64,
  parameter int unsigned CLOSED_AREA     = 900,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic        pix_hit,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        frame_end,
  output logic [15:0] glovex,
  output logic [15:0] glovey,
  output logic        glove_closed,
  output logic        glove_found,
  output logic        pos_valid
);

  localparam int unsigned SUM_W = 28;
  localparam int unsigned CNT_W = 19;

  typedef enum logic [2:0] {
    S_ACCUM,
    S_LATCH,
    S_DIVIDE,
    S_SCALE,
    S_OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sumx_q, sumx_d;
  logic [SUM_W-1:0]   sumy_q, sumy_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   divx_q, divx_d;
  logic [SUM_W-1:0]   divy_q, divy_d;
  logic [CNT_W-1:0]   remx_q, remx_d;
  logic [CNT_W-1:0]   remy_q, remy_d;
  logic [CNT_W-1:0]   divisor_q, divisor_d;
  logic [4:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         deb_q, deb_d;
  logic [15:0]        glovex_q, glovex_d;
  logic [15:0]        glovey_q, glovey_d;
  logic               closed_q, closed_d;
  logic               found_q, found_d;
  logic               pv_q, pv_d;

  logic [CNT_W:0]     remx_sh, remy_sh;
  logic               gex, gey;
  logic [15:0]        newx, newy;
  logic               candidate;

  // Restoring divider step: quotient bits shift into the dividend register from the LSB.
  always_comb begin
    remx_sh = {remx_q, divx_q[SUM_W-1]};
    remy_sh = {remy_q, divy_q[SUM_W-1]};
    gex     = (remx_sh >= {1'b0, divisor_q});
    gey     = (remy_sh >= {1'b0, divisor_q});
  end

  always_comb begin
    newx = 16'(32'(divx_q) * MM_PER_PX_X);
    newy = 16'((32'(FRAME_H - 1) - 32'(divy_q)) * MM_PER_PX_Y);
    candidate = (divisor_q < CNT_W'(CLOSED_AREA));
  end

  always_comb begin
    state_d   = state_q;
    sumx_d    = sumx_q;
    sumy_d    = sumy_q;
    count_d   = count_q;
    divx_d    = divx_q;
    divy_d    = divy_q;
    remx_d    = remx_q;
    remy_d    = remy_q;
    divisor_d = divisor_q;
    bitcnt_d  = bitcnt_q;
    deb_d     = deb_q;
    glovex_d  = glovex_q;
    glovey_d  = glovey_q;
    closed_d  = closed_q;
    found_d   = found_q;
    pv_d      = 1'b0;

    unique case (state_q)
      S_ACCUM: begin
        if (pix_valid && pix_hit) begin
          sumx_d  = sumx_q + SUM_W'(hcount);
          sumy_d  = sumy_q + SUM_W'(vcount);
          count_d = count_q + 1'b1;
        end
        if (frame_end) state_d = S_LATCH;
      end

      S_LATCH: begin
        sumx_d  = '0;
        sumy_d  = '0;
        count_d = '0;
        if (count_q < CNT_W'(MIN_PIXELS)) begin
          found_d = 1'b0;
          pv_d    = 1'b1;
          state_d = S_ACCUM;
        end else begin
          divx_d    = sumx_q;
          divy_d    = sumy_q;
          remx_d    = '0;
          remy_d    = '0;
          divisor_d = count_q;
          bitcnt_d  = '0;
          state_d   = S_DIVIDE;
        end
      end

      S_DIVIDE: begin
        remx_d   = gex ? CNT_W'(remx_sh - {1'b0, divisor_q}) : CNT_W'(remx_sh);
        remy_d   = gey ? CNT_W'(remy_sh - {1'b0, divisor_q}) : CNT_W'(remy_sh);
        divx_d   = {divx_q[SUM_W-2:0], gex};
        divy_d   = {divy_q[SUM_W-2:0], gey};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == 5'(SUM_W - 1)) state_d = S_SCALE;
      end

      S_SCALE: begin
`ifdef GLOVE_TRACKER_SMOOTH_EN
        // found_q low means no trustworthy previous position, so load directly.
        if (found_q) begin
          glovex_d = 16'(({1'b0, glovex_q} + {1'b0, newx}) >> 1);
          glovey_d = 16'(({1'b0, glovey_q} + {1'b0, newy}) >> 1);
        end else begin
          glovex_d = newx;
          glovey_d = newy;
        end
`else
        glovex_d = newx;
        glovey_d = newy;
`endif
        if (candidate == closed_q) begin
          deb_d = '0;
        end else if (deb_q == 8'(DEBOUNCE_FRAMES - 1)) begin
          closed_d = ~closed_q;
          deb_d    = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
        found_d = 1'b1;
        pv_d    = 1'b1;
        state_d = S_OUTPUT;
      end

      S_OUTPUT: state_d = S_ACCUM;

      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ACCUM;
      sumx_q    <= '0;
      sumy_q    <= '0;
      count_q   <= '0;
      divx_q    <= '0;
      divy_q    <= '0;
      remx_q    <= '0;
      remy_q    <= '0;
      divisor_q <= '0;
      bitcnt_q  <= '0;
      deb_q     <= '0;
      glovex_q  <= '0;
      glovey_q  <= '0;
      closed_q  <= 1'b0;
      found_q   <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sumx_q    <= sumx_d;
      sumy_q    <= sumy_d;
      count_q   <= count_d;
      divx_q    <= divx_d;
      divy_q    <= divy_d;
      remx_q    <= remx_d;
      remy_q    <= remy_d;
      divisor_q <= divisor_d;
      bitcnt_q  <= bitcnt_d;
      deb_q     <= deb_d;
      glovex_q  <= glovex_d;
      glovey_q  <= glovey_d;
      closed_q  <= closed_d;
      found_q   <= found_d;
      pv_q      <= pv_d;
    end
  end

  assign glovex       = glovex_q;
  assign glovey       = glovey_q;
  assign glove_closed = closed_q;
  assign glove_found  = found_q;
  assign pos_valid    = pv_q;

endmodule

// File: tb/tb_glove_tracker.sv
// Directed bench for glove_tracker; dut uses defaults, dut2 uses MIN_PIXELS=2.
module tb_glove_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid, pix_hit, frame_end;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [15:0] a_x, a_y, b_x, b_y;
  logic        a_closed, a_found, a_pv, b_closed, b_found, b_pv;
  int checks = 0;
  int failures = 0;

  glove_tracker dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_hit(pix_hit),
    .hcount(hcount), .vcount(vcount), .frame_end(frame_end),
    .glovex(a_x), .glovey(a_y), .glove_closed(a_closed),
    .glove_found(a_found), .pos_valid(a_pv)
  );

  glove_tracker #(.MIN_PIXELS(2)) dut2 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_hit(pix_hit),
    .hcount(hcount), .vcount(vcount), .frame_end(frame_end),
    .glovex(b_x), .glovey(b_y), .glove_closed(b_closed),
    .glove_found(b_found), .pos_valid(b_pv)
  );

  always #5 clk = ~clk;

  task automatic pix(input int x, input int y, input logic v, input logic h);
    pix_valid = v;
    pix_hit   = h;
    hcount    = 11'(x);
    vcount    = 10'(y);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_hit   = 1'b0;
  endtask

  task automatic square(input int x0, input int y0, input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        pix(x0 + c, y0 + r, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // lat counts cycles from the frame_end cycle (cycle 0) to the pos_valid cycle; 0 means none within 40.
  task automatic do_frame_end(output int lat_a, output int lat_b, output int np_a);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    lat_a = 0; lat_b = 0; np_a = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (a_pv) begin np_a++; if (lat_a == 0) lat_a = c; end
      if (b_pv && lat_b == 0) lat_b = c;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (a_x !== 16'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", a_x); end
    if (a_y !== 16'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", a_y); end
    if (a_closed !== 1'b0) begin failures++; $display("FAIL reset_closed got=%0b exp=0", a_closed); end
    if (a_found !== 1'b0) begin failures++; $display("FAIL reset_found got=%0b exp=0", a_found); end
    if (a_pv !== 1'b0) begin failures++; $display("FAIL reset_pv got=%0b exp=0", a_pv); end
  endtask

  task automatic test_square();
    int la, lb, np;
    square(100, 200, 10, 10);
    pix(50, 50, 1'b1, 1'b0);
    pix(60, 60, 1'b0, 1'b1);
    do_frame_end(la, lb, np);
    checks += 6;
    if (la != 31) begin failures++; $display("FAIL sq_latency got=%0d exp=31", la); end
    if (np != 1) begin failures++; $display("FAIL sq_pulses got=%0d exp=1", np); end
    if (a_x !== 16'd416) begin failures++; $display("FAIL sq_x got=%0d exp=416", a_x); end
    if (a_y !== 16'd1100) begin failures++; $display("FAIL sq_y got=%0d exp=1100", a_y); end
    if (a_found !== 1'b1) begin failures++; $display("FAIL sq_found got=%0b exp=1", a_found); end
    if (a_closed !== 1'b0) begin failures++; $display("FAIL sq_closed got=%0b exp=0", a_closed); end
  endtask

  task automatic test_lost();
    int la, lb, np;
    square(300, 300, 8, 5);
    do_frame_end(la, lb, np);
    checks += 6;
    if (la != 2) begin failures++; $display("FAIL lost_latency got=%0d exp=2", la); end
    if (np != 1) begin failures++; $display("FAIL lost_pulses got=%0d exp=1", np); end
    if (a_found !== 1'b0) begin failures++; $display("FAIL lost_found got=%0b exp=0", a_found); end
    if (a_x !== 16'd416) begin failures++; $display("FAIL lost_x got=%0d exp=416", a_x); end
    if (a_y !== 16'd1100) begin failures++; $display("FAIL lost_y got=%0d exp=1100", a_y); end
    if (a_closed !== 1'b0) begin failures++; $display("FAIL lost_closed got=%0b exp=0", a_closed); end
  endtask

  // Busy-state pixels/frame_end must be ignored; second frame checks smoothing or direct load.
  task automatic test_back_to_back();
    int la, np, lb;
    int ex;
    square(100, 200, 10, 10);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    la = 0; np = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (a_pv) begin np++; if (la == 0) la = c; end
      pix_valid = (c >= 3 && c <= 12);
      pix_hit   = (c >= 3 && c <= 12);
      hcount    = 11'd600;
      vcount    = 10'd10;
      frame_end = (c == 15);
    end
    pix_valid = 1'b0; pix_hit = 1'b0; frame_end = 1'b0;
    checks += 5;
    if (la != 31) begin failures++; $display("FAIL b2b_latency got=%0d exp=31", la); end
    if (np != 1) begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", np); end
    if (a_x !== 16'd416) begin failures++; $display("FAIL b2b_x got=%0d exp=416", a_x); end
    if (a_y !== 16'd1100) begin failures++; $display("FAIL b2b_y got=%0d exp=1100", a_y); end
    if (a_closed !== 1'b0) begin failures++; $display("FAIL b2b_closed1 got=%0b exp=0", a_closed); end
`ifdef GLOVE_TRACKER_SMOOTH_EN
    ex = 608;
`else
    ex = 800;
`endif
    square(196, 200, 10, 10);
    do_frame_end(la, lb, np);
    checks += 4;
    if (la != 31) begin failures++; $display("FAIL b2b2_latency got=%0d exp=31", la); end
    if (a_x !== 16'(ex)) begin failures++; $display("FAIL b2b2_x got=%0d exp=%0d", a_x, ex); end
    if (a_y !== 16'd1100) begin failures++; $display("FAIL b2b2_y got=%0d exp=1100", a_y); end
    // third consecutive small frame (first was test_square; lost frame in between does not count)
    if (a_closed !== 1'b1) begin failures++; $display("FAIL b2b2_closed got=%0b exp=1", a_closed); end
  endtask

  task automatic test_debounce();
    int sizes [6] = '{20, 20, 40, 20, 20, 20};
    logic expc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int la, lb, np;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      square(100, 100, sizes[f], sizes[f]);
      do_frame_end(la, lb, np);
      checks += 2;
      if (la != 31) begin failures++; $display("FAIL deb_latency f=%0d got=%0d exp=31", f, la); end
      if (a_closed !== expc[f]) begin failures++; $display("FAIL deb_closed f=%0d got=%0b exp=%0b", f, a_closed, expc[f]); end
    end
  endtask

  task automatic test_reset_divide();
    int la, lb, np;
    square(100, 200, 10, 10);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    np = 0;
    for (int c = 0; c < 40; c++) begin
      if (a_pv) np++;
      @(posedge clk); #1;
    end
    checks += 5;
    if (np != 0) begin failures++; $display("FAIL rstdiv_pulses got=%0d exp=0", np); end
    if (a_x !== 16'd0) begin failures++; $display("FAIL rstdiv_x got=%0d exp=0", a_x); end
    if (a_y !== 16'd0) begin failures++; $display("FAIL rstdiv_y got=%0d exp=0", a_y); end
    if (a_found !== 1'b0) begin failures++; $display("FAIL rstdiv_found got=%0b exp=0", a_found); end
    if (a_closed !== 1'b0) begin failures++; $display("FAIL rstdiv_closed got=%0b exp=0", a_closed); end
    square(0, 0, 10, 10);
    do_frame_end(la, lb, np);
    checks += 4;
    if (la != 31) begin failures++; $display("FAIL origin_latency got=%0d exp=31", la); end
    if (a_x !== 16'd16) begin failures++; $display("FAIL origin_x got=%0d exp=16", a_x); end
    if (a_y !== 16'd1900) begin failures++; $display("FAIL origin_y got=%0d exp=1900", a_y); end
    if (a_found !== 1'b1) begin failures++; $display("FAIL origin_found got=%0b exp=1", a_found); end
  endtask

  task automatic test_two_hits();
    int la, lb, np;
    do_reset();
    pix(639, 479, 1'b1, 1'b1);
    pix(300, 300, 1'b1, 1'b0);
    pix(5, 5, 1'b0, 1'b1);
    pix(0, 0, 1'b1, 1'b1);
    do_frame_end(la, lb, np);
    checks += 6;
    if (lb != 31) begin failures++; $display("FAIL two_latency got=%0d exp=31", lb); end
    if (b_x !== 16'd1276) begin failures++; $display("FAIL two_x got=%0d exp=1276", b_x); end
    if (b_y !== 16'd960) begin failures++; $display("FAIL two_y got=%0d exp=960", b_y); end
    if (b_found !== 1'b1) begin failures++; $display("FAIL two_found got=%0b exp=1", b_found); end
    if (la != 2) begin failures++; $display("FAIL two_dflt_latency got=%0d exp=2", la); end
    if (a_found !== 1'b0) begin failures++; $display("FAIL two_dflt_found got=%0b exp=0", a_found); end
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_hit = 1'b0; frame_end = 1'b0;
    hcount = '0; vcount = '0;
    @(posedge clk); #1;
    test_reset();
    test_square();
    test_lost();
    test_back_to_back();
    test_debounce();
    test_reset_divide();
    test_two_hits();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
